// File: rtl/baby_fetch_sequencer.sv
// Fetch/execute sequencer for the Baby: steps the program counter, fetches the
// present instruction from the store, decodes it and strobes the datapath.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for RUN or a STEP pulse, all strobes inactive
// INC    | program counter counts up by one
// FETCH  | store read at CI, PI captured at end of cycle
// DECODE | FUNC/LINE settle from PI, no strobes
// EXEC   | operand addressed by LINE, action selected by FUNC
// SKIP   | CMP taken: extra counter increment skips next instruction
// STOP   | STP executed, halted until reset
module baby_fetch_sequencer #(
    parameter int LINE_BITS = 5,
    parameter int FUNC_LSB  = 13
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RUN,
    input  logic                 STEP,
    input  logic [31:0]          STORE_DATA,
    input  logic                 ACC_NEG,
    output logic                 PC_INC,
    output logic                 PC_LOAD_n,
    output logic                 PC_SRC,
    output logic                 PC_OE_n,
    output logic                 ADDR_SEL,
    output logic                 STORE_RD_n,
    output logic                 STORE_WR_n,
    output logic                 ACC_LOAD,
    output logic                 ACC_SUB,
    output logic [2:0]           FUNC,
    output logic [LINE_BITS-1:0] LINE,
    output logic                 HALTED,
    output logic [2:0]           STATE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INC    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SKIP   = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    state_t      state_q, state_nxt;
    logic [31:0] pi_q;
    logic        step_flag_q, step_flag_nxt;
    logic        go_idle;
    logic        unused_pi_bits;

    assign FUNC   = pi_q[FUNC_LSB+2:FUNC_LSB];
    assign LINE   = pi_q[LINE_BITS-1:0];
    assign STATE  = state_q;
    assign HALTED = (state_q == ST_STOP);

    // Only the function and line fields are decoded; the rest of PI is don't-care.
    assign unused_pi_bits = ^{pi_q[31:FUNC_LSB+3], pi_q[FUNC_LSB-1:LINE_BITS]};

    // End of an instruction: stop after a single step or once RUN has dropped.
    assign go_idle = step_flag_q | ~RUN;

    // State, single-step flag and present-instruction registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            step_flag_q <= 1'b0;
            pi_q        <= '0;
        end else begin
            state_q     <= state_nxt;
            step_flag_q <= step_flag_nxt;
            if (state_q == ST_FETCH) begin
                pi_q <= STORE_DATA;
            end
        end
    end

    // Next-state selection and per-state strobe decode.
    always_comb begin
        state_nxt     = state_q;
        step_flag_nxt = step_flag_q;
        PC_INC        = 1'b0;
        PC_LOAD_n     = 1'b1;
        PC_SRC        = 1'b0;
        PC_OE_n       = 1'b1;
        ADDR_SEL      = 1'b0;
        STORE_RD_n    = 1'b1;
        STORE_WR_n    = 1'b1;
        ACC_LOAD      = 1'b0;
        ACC_SUB       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RUN || STEP) begin
                    state_nxt     = ST_INC;
                    // RUN takes precedence when both are present.
                    step_flag_nxt = STEP & ~RUN;
                end
            end
            ST_INC: begin
                PC_INC    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                PC_OE_n    = 1'b0;
                STORE_RD_n = 1'b0;
                state_nxt  = ST_DECODE;
            end
            ST_DECODE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                ADDR_SEL  = 1'b1;
                state_nxt = go_idle ? ST_IDLE : ST_INC;
                case (FUNC)
                    3'd0: begin
                        STORE_RD_n = 1'b0;
                        PC_LOAD_n  = 1'b0;
                    end
                    3'd1: begin
                        STORE_RD_n = 1'b0;
                        PC_LOAD_n  = 1'b0;
                        PC_SRC     = 1'b1;
                    end
                    3'd2: begin
                        STORE_RD_n = 1'b0;
                        ACC_LOAD   = 1'b1;
                    end
                    3'd3: begin
                        STORE_WR_n = 1'b0;
                    end
                    3'd4, 3'd5: begin
                        STORE_RD_n = 1'b0;
                        ACC_SUB    = 1'b1;
                    end
                    3'd6: begin
                        if (ACC_NEG) begin
                            state_nxt = ST_SKIP;
                        end
                    end
                    default: begin
                        state_nxt = ST_STOP;
                    end
                endcase
                if (state_nxt == ST_IDLE) begin
                    step_flag_nxt = 1'b0;
                end
            end
            ST_SKIP: begin
                PC_INC    = 1'b1;
                state_nxt = go_idle ? ST_IDLE : ST_INC;
                if (go_idle) begin
                    step_flag_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                state_nxt = ST_STOP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_baby_fetch_sequencer.sv
// Bench for the fetch/execute sequencer: expected strobe cycles are queued per
// instruction from a transaction-level model and matched by a cycle monitor.
module tb_baby_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, RUN, STEP, ACC_NEG;
    logic [31:0] STORE_DATA;
    logic        PC_INC, PC_LOAD_n, PC_SRC, PC_OE_n, ADDR_SEL;
    logic        STORE_RD_n, STORE_WR_n, ACC_LOAD, ACC_SUB, HALTED;
    logic [2:0]  FUNC, STATE;
    logic [4:0]  LINE;

    baby_fetch_sequencer #(.LINE_BITS(5), .FUNC_LSB(13)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
        .STORE_DATA(STORE_DATA), .ACC_NEG(ACC_NEG),
        .PC_INC(PC_INC), .PC_LOAD_n(PC_LOAD_n), .PC_SRC(PC_SRC), .PC_OE_n(PC_OE_n),
        .ADDR_SEL(ADDR_SEL), .STORE_RD_n(STORE_RD_n), .STORE_WR_n(STORE_WR_n),
        .ACC_LOAD(ACC_LOAD), .ACC_SUB(ACC_SUB), .FUNC(FUNC), .LINE(LINE),
        .HALTED(HALTED), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_inc, load_n, src, oe_n, addr_sel, rd_n, wr_n, acc_load, acc_sub;
        logic [2:0] func;
        logic [4:0] line;
        logic       halted;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pi_model;

    // Output record for a cycle with every strobe inactive.
    function automatic obs_t quiet(input logic [2:0] st, input logic [31:0] pi);
        obs_t o;
        o.state = st;   o.pc_inc = 1'b0; o.load_n = 1'b1; o.src = 1'b0;
        o.oe_n = 1'b1;  o.addr_sel = 1'b0; o.rd_n = 1'b1; o.wr_n = 1'b1;
        o.acc_load = 1'b0; o.acc_sub = 1'b0;
        o.func = pi[15:13]; o.line = pi[4:0]; o.halted = (st == 3'd6);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state = STATE; o.pc_inc = PC_INC; o.load_n = PC_LOAD_n; o.src = PC_SRC;
        o.oe_n = PC_OE_n; o.addr_sel = ADDR_SEL; o.rd_n = STORE_RD_n; o.wr_n = STORE_WR_n;
        o.acc_load = ACC_LOAD; o.acc_sub = ACC_SUB; o.func = FUNC; o.line = LINE;
        o.halted = HALTED;
        return o;
    endfunction

    function automatic bit strobing(input obs_t o);
        return o.pc_inc | ~o.load_n | ~o.rd_n | ~o.wr_n | o.acc_load | o.acc_sub;
    endfunction

    // Queue every strobing cycle one instruction produces.
    task automatic push_instr(input logic [31:0] w, input logic neg);
        obs_t o;
        logic [2:0] f;
        f = w[15:13];
        o = quiet(3'd1, pi_model); o.pc_inc = 1'b1; exp_q.push_back(o);
        o = quiet(3'd2, pi_model); o.oe_n = 1'b0; o.rd_n = 1'b0; exp_q.push_back(o);
        pi_model = w;
        o = quiet(3'd4, w); o.addr_sel = 1'b1;
        case (f)
            3'd0: begin o.rd_n = 1'b0; o.load_n = 1'b0; end
            3'd1: begin o.rd_n = 1'b0; o.load_n = 1'b0; o.src = 1'b1; end
            3'd2: begin o.rd_n = 1'b0; o.acc_load = 1'b1; end
            3'd3: o.wr_n = 1'b0;
            3'd4, 3'd5: begin o.rd_n = 1'b0; o.acc_sub = 1'b1; end
            default: ;
        endcase
        if (f <= 3'd5) exp_q.push_back(o);
        if (f == 3'd6 && neg) begin
            o = quiet(3'd5, w); o.pc_inc = 1'b1; exp_q.push_back(o);
        end
    endtask

    task automatic check_obs(input string name, input obs_t e);
        obs_t o;
        o = sample();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, o, e);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: legality every cycle, scoreboard match on every strobing cycle.
    always @(negedge CLK) begin : monitor
        obs_t o, e;
        o = sample();
        checks++;
        if ((o.pc_inc && !o.load_n) || (!o.rd_n && !o.wr_n)) begin
            errors++;
            $display("FAIL exclusive_strobes: got %h expected no conflicting strobes", o);
        end
        if (strobing(o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected no strobes", o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", o, e);
                end
            end
        end
    end

    // One episode: k instructions under RUN (dropped in the last one), or one STEP.
    task automatic run_episode(input logic [31:0] w, input logic neg, input bit use_run,
                               input int k, input bit with_step);
        int len, n, j;
        STORE_DATA = w;
        ACC_NEG    = neg;
        len = (w[15:13] == 3'd6 && neg) ? 5 : 4;
        if (!use_run) k = 1;
        for (int i = 0; i < k; i++) push_instr(w, neg);
        if (use_run) begin
            RUN = 1'b1; STEP = with_step;
            @(posedge CLK); #1; STEP = 1'b0;
            j = $urandom_range(len - 1);
            n = len * (k - 1) + j;
            if (n >= 2) begin
                @(posedge CLK); #1; STEP = 1'b1;
                @(posedge CLK); #1; STEP = 1'b0;
                n -= 2;
            end
            repeat (n) @(posedge CLK);
            #1; RUN = 1'b0;
        end else begin
            STEP = 1'b1;
            @(posedge CLK); #1; STEP = 1'b0;
        end
        repeat (len + 2) @(posedge CLK);
        #1;
        check_obs("idle_after_episode", quiet(3'd0, w));
        check_drained("events_drained");
    endtask

    initial begin
        logic [31:0] w;
        RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; ACC_NEG = 1'b0; STORE_DATA = '0;
        pi_model = '0;
        repeat (3) @(posedge CLK);
        #1; RESET = 1'b0;
        check_obs("reset_state", quiet(3'd0, 32'h0));

        // Reset during FETCH: PI must not be captured.
        STORE_DATA = 32'h0000_6003;
        push_instr(32'h0000_6003, 1'b0);
        exp_q.pop_back();
        pi_model = '0;
        STEP = 1'b1;
        @(posedge CLK); #1; STEP = 1'b0;
        @(posedge CLK); #1; RESET = 1'b1;
        @(posedge CLK); #1; RESET = 1'b0;
        check_obs("reset_mid_fetch", quiet(3'd0, 32'h0));
        check_drained("reset_mid_fetch_drained");

        run_episode(32'h0000_6003, 1'b0, 1'b1, 1, 1'b0);
        run_episode(32'h0000_2005, 1'b0, 1'b1, 1, 1'b0);
        run_episode(32'h0000_0005, 1'b0, 1'b0, 1, 1'b0);
        run_episode(32'h0000_C000, 1'b1, 1'b1, 2, 1'b0);
        run_episode(32'h0000_C000, 1'b0, 1'b1, 2, 1'b0);
        run_episode(32'h0000_4007, 1'b0, 1'b0, 1, 1'b0);
        run_episode(32'h0000_C000, 1'b1, 1'b0, 1, 1'b0);
        run_episode(32'hFFFF_9FFF, 1'b0, 1'b1, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            w[15:13] = 3'($urandom_range(6));
            run_episode(w, 1'($urandom_range(1)), 1'($urandom_range(1)),
                        $urandom_range(1, 4), 1'($urandom_range(1)));
        end

        // STP halts until reset regardless of RUN/STEP.
        w = 32'h0000_E00A;
        STORE_DATA = w;
        push_instr(w, 1'b0);
        STEP = 1'b1;
        @(posedge CLK); #1; STEP = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check_obs("stop_entry", quiet(3'd6, w));
        for (int i = 0; i < 20; i++) begin
            RUN  = 1'($urandom_range(1));
            STEP = 1'($urandom_range(1));
            @(posedge CLK); #1;
            check_obs("stop_hold", quiet(3'd6, w));
        end
        RUN = 1'b0; STEP = 1'b0; RESET = 1'b1;
        @(posedge CLK); #1; RESET = 1'b0;
        pi_model = '0;
        check_obs("reset_from_stop", quiet(3'd0, 32'h0));
        check_drained("final_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
